// File: rtl/match_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module   : match_scoreboard_if
//  Purpose  : Game-result and scoreboard signal bundle between the game core
//             side and the match scoreboard.
//  Revision : 1.0
// ============================================================================
interface match_scoreboard_if;
    logic [1:0] game_result;
    logic       next_btn;
    logic       round_reset;
    logic [3:0] player_score;
    logic [3:0] ai_score;
    logic [3:0] draw_count;
    logic [3:0] round_num;
    logic [1:0] last_result;
    logic       match_over;
    logic [1:0] match_winner;

    modport master (
        output game_result,
        output next_btn,
        input  round_reset,
        input  player_score,
        input  ai_score,
        input  draw_count,
        input  round_num,
        input  last_result,
        input  match_over,
        input  match_winner
    );

    modport slave (
        input  game_result,
        input  next_btn,
        output round_reset,
        output player_score,
        output ai_score,
        output draw_count,
        output round_num,
        output last_result,
        output match_over,
        output match_winner
    );
endinterface
`default_nettype wire

// File: rtl/match_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : match_scoreboard
//  Purpose  : Tallies round results from the game core, holds each result,
//             restarts rounds and declares the match winner.
//  Revision : 1.0
// ============================================================================
module match_scoreboard #(
    parameter int unsigned HOLD_CYCLES   = 200_000_000,
    parameter int unsigned WINS_TO_MATCH = 3
) (
    input wire                clk,
    input wire                reset_flag,
    match_scoreboard_if.slave sb
);

    localparam int unsigned c_CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [3:0] c_WINS = 4'(WINS_TO_MATCH);

    localparam logic [1:0] c_RES_NONE   = 2'b00;
    localparam logic [1:0] c_RES_PLAYER = 2'b01;
    localparam logic [1:0] c_RES_AI     = 2'b10;
    localparam logic [1:0] c_RES_DRAW   = 2'b11;

    typedef enum logic [2:0] {
        PLAY       = 3'd0,
        TALLY      = 3'd1,
        HOLD       = 3'd2,
        NEXT       = 3'd3,
        WAIT_CLEAR = 3'd4,
        MATCH_OVER = 3'd5
    } state_t;

    state_t             r_state,        w_state_nxt;
    logic [c_CNT_W-1:0] r_hold_cnt,     w_hold_cnt_nxt;
    logic [3:0]         r_player_score, w_player_score_nxt;
    logic [3:0]         r_ai_score,     w_ai_score_nxt;
    logic [3:0]         r_draw_count,   w_draw_count_nxt;
    logic [3:0]         r_round_num,    w_round_num_nxt;
    logic [1:0]         r_last_result,  w_last_result_nxt;
    logic [1:0]         r_match_winner, w_match_winner_nxt;
    logic               r_round_reset,  w_round_reset_nxt;
    logic               r_match_over,   w_match_over_nxt;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset_flag) begin
            r_state        <= PLAY;
            r_hold_cnt     <= '0;
            r_player_score <= 4'd0;
            r_ai_score     <= 4'd0;
            r_draw_count   <= 4'd0;
            r_round_num    <= 4'd1;
            r_last_result  <= c_RES_NONE;
            r_match_winner <= c_RES_NONE;
            r_round_reset  <= 1'b0;
            r_match_over   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_hold_cnt     <= w_hold_cnt_nxt;
            r_player_score <= w_player_score_nxt;
            r_ai_score     <= w_ai_score_nxt;
            r_draw_count   <= w_draw_count_nxt;
            r_round_num    <= w_round_num_nxt;
            r_last_result  <= w_last_result_nxt;
            r_match_winner <= w_match_winner_nxt;
            r_round_reset  <= w_round_reset_nxt;
            r_match_over   <= w_match_over_nxt;
        end
    end

    // Outputs are computed one edge early so every port is a plain register.
    always_comb begin
        w_state_nxt        = r_state;
        w_hold_cnt_nxt     = r_hold_cnt;
        w_player_score_nxt = r_player_score;
        w_ai_score_nxt     = r_ai_score;
        w_draw_count_nxt   = r_draw_count;
        w_round_num_nxt    = r_round_num;
        w_last_result_nxt  = r_last_result;
        w_match_winner_nxt = r_match_winner;
        w_round_reset_nxt  = 1'b0;

        case (r_state)
            PLAY: begin
                if (sb.game_result != c_RES_NONE) begin
                    w_last_result_nxt = sb.game_result;
                    w_state_nxt       = TALLY;
                end
            end
            TALLY: begin
                w_hold_cnt_nxt = c_HOLD_LOAD;
                w_state_nxt    = HOLD;
                case (r_last_result)
                    c_RES_PLAYER: begin
                        w_player_score_nxt = sat_inc(r_player_score);
                        if (w_player_score_nxt == c_WINS) begin
                            w_match_winner_nxt = c_RES_PLAYER;
                            w_state_nxt        = MATCH_OVER;
                        end
                    end
                    c_RES_AI: begin
                        w_ai_score_nxt = sat_inc(r_ai_score);
                        if (w_ai_score_nxt == c_WINS) begin
                            w_match_winner_nxt = c_RES_AI;
                            w_state_nxt        = MATCH_OVER;
                        end
                    end
                    c_RES_DRAW: w_draw_count_nxt = sat_inc(r_draw_count);
                    default: ;
                endcase
            end
            HOLD: begin
                if ((r_hold_cnt == '0) || sb.next_btn) begin
                    w_round_num_nxt   = sat_inc(r_round_num);
                    w_round_reset_nxt = 1'b1;
                    w_state_nxt       = NEXT;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - 1'b1;
                end
            end
            NEXT: w_state_nxt = WAIT_CLEAR;
            // A result still showing from the finished round must not be re-tallied.
            WAIT_CLEAR: begin
                if (sb.game_result == c_RES_NONE)
                    w_state_nxt = PLAY;
            end
            MATCH_OVER: begin
                if (sb.next_btn) begin
                    w_player_score_nxt = 4'd0;
                    w_ai_score_nxt     = 4'd0;
                    w_draw_count_nxt   = 4'd0;
                    w_round_num_nxt    = 4'd1;
                    w_last_result_nxt  = c_RES_NONE;
                    w_match_winner_nxt = c_RES_NONE;
                    w_round_reset_nxt  = 1'b1;
                    w_state_nxt        = NEXT;
                end
            end
            default: w_state_nxt = PLAY;
        endcase

        w_match_over_nxt = (w_state_nxt == MATCH_OVER);
    end

    assign sb.round_reset  = r_round_reset;
    assign sb.player_score = r_player_score;
    assign sb.ai_score     = r_ai_score;
    assign sb.draw_count   = r_draw_count;
    assign sb.round_num    = r_round_num;
    assign sb.last_result  = r_last_result;
    assign sb.match_over   = r_match_over;
    assign sb.match_winner = r_match_winner;

endmodule
`default_nettype wire
